// File: rtl/coherence_control_n.sv
// coherence_control_n: snooping MSI coherence controller and RAM arbiter for CPUS dcaches.
// One granted cache at a time (round-robin). Block transfers are sequenced beat by beat;
// a Modified holder supplies the block directly and the data is written through to RAM.
module coherence_control_n #(
    parameter  int CPUS  = 4,
    parameter  int WORDS = 2,
    parameter  int AW    = 32,
    localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int IW    = $clog2(CPUS)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0]      cctrans,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   dload,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS*AW-1:0]   ccsnoopaddr,
    output logic [BW-1:0]        ccbeat,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic                 ramwait
);

    localparam int            OFS       = ((WORDS > 1) ? $clog2(WORDS) : 0) + 2;
    localparam logic [AW-1:0] BASE_MASK = ~((AW'(1) << OFS) - AW'(1));

    typedef enum logic [2:0] {
        IDLE, SNOOP, RD, C2C, DONE, WB, UPG1, UPG2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   grant_reg, grant_next;
    logic [IW-1:0]   req_reg, req_next;
    logic [IW-1:0]   sup_reg, sup_next;
    logic [AW-1:0]   base_reg, base_next;
    logic            trans_reg, trans_next;
    logic [BW-1:0]   beat_reg, beat_next;

    logic [AW-1:0]   daddr_a  [CPUS];
    logic [31:0]     dstore_a [CPUS];
    logic [31:0]     dload_a  [CPUS];
    logic [CPUS-1:0] req_any;
    logic [CPUS-1:0] req_onehot;
    logic [CPUS-1:0] others;
    logic [CPUS-1:0] snoop_hits;
    logic [AW-1:0]   beat_addr;
    logic            last_beat;

    // Flat port vectors viewed as per-cache arrays; every snoop address carries the granted base.
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_cache
        assign daddr_a[gi]                  = daddr[gi*AW +: AW];
        assign dstore_a[gi]                 = dstore[gi*32 +: 32];
        assign dload[gi*32 +: 32]           = dload_a[gi];
        assign ccsnoopaddr[gi*AW +: AW]     = base_reg;
    end

    assign req_any    = dREN | dWEN | cctrans;
    assign req_onehot = CPUS'(1) << req_reg;
    assign others     = ~req_onehot;
    assign snoop_hits = ccwrite & others;
    assign beat_addr  = base_reg + (AW'(beat_reg) << 2);
    assign last_beat  = (beat_reg == BW'(WORDS - 1));
    assign ccbeat     = beat_reg;

    // Transaction state register; reset abandons any block in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            grant_reg <= IW'(CPUS - 1);
            req_reg   <= '0;
            sup_reg   <= '0;
            base_reg  <= '0;
            trans_reg <= 1'b0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            req_reg   <= req_next;
            sup_reg   <= sup_next;
            base_reg  <= base_next;
            trans_reg <= trans_next;
            beat_reg  <= beat_next;
        end
    end

    // Next-state: round-robin pick in IDLE, snoop resolution, beat sequencing.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        logic [IW-1:0] sup_pick;
        state_next = state_reg;
        grant_next = grant_reg;
        req_next   = req_reg;
        sup_next   = sup_reg;
        base_next  = base_reg;
        trans_next = trans_reg;
        beat_next  = beat_reg;
        found      = 1'b0;
        cand       = '0;
        sup_pick   = '0;
        case (state_reg)
            IDLE: begin
                // Scan starts just after the last served cache, so it is checked last.
                for (int k = 1; k <= CPUS; k++) begin
                    cand = IW'((int'(grant_reg) + k) % CPUS);
                    if (!found && req_any[cand]) begin
                        found      = 1'b1;
                        req_next   = cand;
                        base_next  = daddr_a[cand] & BASE_MASK;
                        trans_next = cctrans[cand];
                        beat_next  = '0;
                        if (dREN[cand])      state_next = SNOOP;
                        else if (dWEN[cand]) state_next = WB;
                        else                 state_next = UPG1;
                    end
                end
            end
            SNOOP: begin
                // Lowest-index Modified holder supplies; MSI allows at most one.
                for (int i = CPUS - 1; i >= 0; i--) begin
                    if (snoop_hits[i]) sup_pick = IW'(i);
                end
                if (|snoop_hits) begin
                    sup_next   = sup_pick;
                    state_next = C2C;
                end else begin
                    state_next = RD;
                end
            end
            RD, C2C, WB: begin
                if (!ramwait) begin
                    if (last_beat) begin
                        beat_next = '0;
                        if (state_reg == WB) begin
                            grant_next = req_reg;
                            state_next = IDLE;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        beat_next = beat_reg + BW'(1);
                    end
                end
            end
            DONE: begin
                grant_next = req_reg;
                state_next = IDLE;
            end
            UPG1: state_next = UPG2;
            UPG2: begin
                grant_next = req_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: everyone waits and sees zero load data unless the current state routes to them.
    always_comb begin
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int i = 0; i < CPUS; i++) dload_a[i] = '0;
        case (state_reg)
            SNOOP: ccwait = others;
            RD: begin
                ccwait           = others;
                ramREN           = 1'b1;
                ramaddr          = beat_addr;
                dload_a[req_reg] = ramload;
                dwait[req_reg]   = ramwait;
            end
            C2C: begin
                // Supplier and requestor advance together, paced by the RAM write-through.
                ccwait           = others;
                ramWEN           = 1'b1;
                ramaddr          = beat_addr;
                ramstore         = dstore_a[sup_reg];
                dload_a[req_reg] = dstore_a[sup_reg];
                dwait[req_reg]   = ramwait;
                dwait[sup_reg]   = ramwait;
            end
            DONE: begin
                if (trans_reg) begin
                    ccinv  = others;
                    ccwait = others;
                end
            end
            WB: begin
                ramWEN         = 1'b1;
                ramaddr        = beat_addr;
                ramstore       = dstore_a[req_reg];
                dwait[req_reg] = ramwait;
            end
            UPG1: ccwait = others;
            UPG2: begin
                ccinv          = others;
                dwait[req_reg] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_control_n.sv
// tb_coherence_control_n: directed scenarios for the 4-cache, 2-word coherence controller.
module tb_coherence_control_n;

    localparam int CPUS  = 4;
    localparam int WORDS = 2;
    localparam int AW    = 32;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [CPUS-1:0]     dREN, dWEN, cctrans, ccwrite;
    logic [CPUS*AW-1:0]  daddr;
    logic [CPUS*32-1:0]  dstore;
    logic [CPUS-1:0]     dwait, ccwait, ccinv;
    logic [CPUS*32-1:0]  dload;
    logic [CPUS*AW-1:0]  ccsnoopaddr;
    logic [0:0]          ccbeat;
    logic                ramREN, ramWEN;
    logic [AW-1:0]       ramaddr;
    logic [31:0]         ramstore, ramload;
    logic                ramwait;

    logic [31:0]         store_base [CPUS];
    logic [1:0]          ram_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic         ren;
        logic         wen;
        logic         rw;
        logic [31:0]  addr;
        logic [31:0]  store;
        logic [127:0] dl;
        logic [3:0]   dw;
        logic [3:0]   ccw;
        logic [3:0]   cci;
    } smp_t;

    smp_t log_q[$];
    smp_t comps[$];

    coherence_control_n #(.CPUS(CPUS), .WORDS(WORDS), .AW(AW)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
        .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .ccbeat(ccbeat),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait)
    );

    always #5 CLK = ~CLK;

    // Cache store data: per-cache base plus the byte offset of the current beat.
    always_comb begin
        for (int i = 0; i < CPUS; i++) dstore[i*32 +: 32] = store_base[i] + (32'(ccbeat) << 2);
    end

    // RAM model: each beat waits two cycles, completes on the third; data tagged by address.
    assign ramload = {16'hD0D0, ramaddr[15:0]};
    assign ramwait = (ram_cnt < 2'd2);
    always @(posedge CLK) begin
        if (!nRST || !(ramREN || ramWEN) || !ramwait) ram_cnt <= 2'd0;
        else                                           ram_cnt <= ram_cnt + 2'd1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        smp_t s;
        @(negedge CLK);
        s.ren = ramREN; s.wen = ramWEN; s.rw = ramwait;
        s.addr = ramaddr; s.store = ramstore; s.dl = dload;
        s.dw = dwait; s.ccw = ccwait; s.cci = ccinv;
        log_q.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) sample();
    endtask

    // Run until cache `cpu` has completed n beats, then it withdraws its request.
    task automatic wait_done(input string tag, input int cpu, input int n, input int maxc);
        int cnt = 0;
        for (int c = 0; c < maxc && cnt < n; c++) begin
            sample();
            if (dwait[cpu] == 1'b0) cnt++;
        end
        check_eq({tag, "_beats_done"}, 128'(cnt), 128'(n));
        dREN[cpu] = 1'b0; dWEN[cpu] = 1'b0; cctrans[cpu] = 1'b0;
        $display("txn %s cpu%0d beats=%0d", tag, cpu, cnt);
    endtask

    task automatic collect(input logic want_wen);
        comps.delete();
        foreach (log_q[i]) begin
            if ((want_wen ? log_q[i].wen : log_q[i].ren) && !log_q[i].rw) comps.push_back(log_q[i]);
        end
    endtask

    initial begin
        int   n_inv, i0, bad, first;
        logic [3:0] inv_val, ccw_at_inv, any_inv;
        logic any_wen, any_ren;
        int   order[$];
        int   cnt5 [CPUS];

        nRST = 1'b0;
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; daddr = '0;
        for (int i = 0; i < CPUS; i++) store_base[i] = '0;

        // Reset state
        @(negedge CLK);
        check_eq("rst_dwait",  128'(dwait), 128'(4'hF));
        check_eq("rst_ccwait", 128'(ccwait), 128'(0));
        check_eq("rst_ccinv",  128'(ccinv), 128'(0));
        check_eq("rst_ram_en", 128'({ramREN, ramWEN}), 128'(0));
        check_eq("rst_ramaddr", 128'(ramaddr), 128'(0));
        check_eq("rst_ramstore", 128'(ramstore), 128'(0));
        check_eq("rst_dload", 128'(dload), 128'(0));
        check_eq("rst_beat", 128'(ccbeat), 128'(0));
        nRST = 1'b1;

        // 1: CPU2 read miss, nobody holds it Modified; 0x104 lies in block 0x100.
        log_q.delete();
        daddr[2*AW +: AW] = 32'h104;
        dREN[2] = 1'b1;
        wait_done("s1", 2, 2, 60);
        idle(3);
        collect(1'b0);
        check_eq("s1_nbeats", 128'(comps.size()), 128'd2);
        if (comps.size() == 2) begin
            check_eq("s1_addr0", 128'(comps[0].addr), 128'h100);
            check_eq("s1_addr1", 128'(comps[1].addr), 128'h104);
            check_eq("s1_dload0", comps[0].dl, {32'h0, 32'hD0D00100, 64'h0});
            check_eq("s1_dload1", comps[1].dl, {32'h0, 32'hD0D00104, 64'h0});
            check_eq("s1_ccwait", 128'(comps[0].ccw), 128'(4'b1011));
        end
        any_inv = '0; any_wen = 1'b0;
        foreach (log_q[i]) begin any_inv |= log_q[i].cci; any_wen |= log_q[i].wen; end
        check_eq("s1_no_inv", 128'(any_inv), 128'(0));
        check_eq("s1_no_wen", 128'(any_wen), 128'(0));

        // 2: CPU0 read miss, CPU3 holds it Modified and supplies.
        log_q.delete();
        store_base[3] = 32'hAAAA0000;
        ccwrite[3] = 1'b1;
        daddr[0 +: AW] = 32'h200;
        dREN[0] = 1'b1;
        wait_done("s2", 0, 2, 60);
        ccwrite[3] = 1'b0;
        idle(3);
        collect(1'b1);
        check_eq("s2_nbeats", 128'(comps.size()), 128'd2);
        if (comps.size() == 2) begin
            check_eq("s2_addr0", 128'(comps[0].addr), 128'h200);
            check_eq("s2_addr1", 128'(comps[1].addr), 128'h204);
            check_eq("s2_store0", 128'(comps[0].store), 128'hAAAA0000);
            check_eq("s2_store1", 128'(comps[1].store), 128'hAAAA0004);
            check_eq("s2_dload0", comps[0].dl, {96'h0, 32'hAAAA0000});
            check_eq("s2_dload1", comps[1].dl, {96'h0, 32'hAAAA0004});
        end
        bad = 0; any_inv = '0; any_ren = 1'b0;
        foreach (log_q[i]) begin
            if (log_q[i].wen && (log_q[i].dw[3] !== log_q[i].rw || log_q[i].dw[0] !== log_q[i].rw)) bad++;
            any_inv |= log_q[i].cci; any_ren |= log_q[i].ren;
        end
        check_eq("s2_dwait_follow", 128'(bad), 128'(0));
        check_eq("s2_no_inv", 128'(any_inv), 128'(0));
        check_eq("s2_no_ren", 128'(any_ren), 128'(0));
        check_eq("s2_snoopaddr", 128'(ccsnoopaddr), {4{32'h200}});

        // 3: CPU1 write miss, CPU0 holds it Modified; others invalidated once in DONE.
        log_q.delete();
        store_base[0] = 32'hBBBB0000;
        ccwrite[0] = 1'b1;
        daddr[1*AW +: AW] = 32'h300;
        dREN[1] = 1'b1; cctrans[1] = 1'b1;
        wait_done("s3", 1, 2, 60);
        ccwrite[0] = 1'b0;
        idle(3);
        collect(1'b1);
        check_eq("s3_nbeats", 128'(comps.size()), 128'd2);
        if (comps.size() == 2) begin
            check_eq("s3_addr1", 128'(comps[1].addr), 128'h304);
            check_eq("s3_store0", 128'(comps[0].store), 128'hBBBB0000);
            check_eq("s3_dload1", comps[1].dl, {64'h0, 32'hBBBB0004, 32'h0});
        end
        n_inv = 0; inv_val = '0; ccw_at_inv = '0;
        foreach (log_q[i]) begin
            if (log_q[i].cci != 4'b0) begin n_inv++; inv_val = log_q[i].cci; ccw_at_inv = log_q[i].ccw; end
        end
        check_eq("s3_inv_cycles", 128'(n_inv), 128'd1);
        check_eq("s3_inv_mask", 128'(inv_val), 128'(4'b1101));
        check_eq("s3_inv_ccwait", 128'(ccw_at_inv), 128'(4'b1101));

        // 4: CPU1 upgrade (write hit on a clean block): stall, then invalidate, no RAM.
        log_q.delete();
        daddr[1*AW +: AW] = 32'h400;
        cctrans[1] = 1'b1;
        wait_done("s4", 1, 1, 20);
        idle(3);
        i0 = -1; any_wen = 1'b0; any_ren = 1'b0; n_inv = 0;
        foreach (log_q[i]) begin
            if (i0 < 0 && log_q[i].ccw != 4'b0) i0 = i;
            any_wen |= log_q[i].wen; any_ren |= log_q[i].ren;
            if (log_q[i].cci != 4'b0) n_inv++;
        end
        check_eq("s4_found", 128'(i0 >= 0 && i0 + 1 < log_q.size()), 128'd1);
        if (i0 >= 0 && i0 + 1 < log_q.size()) begin
            check_eq("s4_c1_ccwait", 128'(log_q[i0].ccw), 128'(4'b1101));
            check_eq("s4_c1_ccinv", 128'(log_q[i0].cci), 128'(0));
            check_eq("s4_c2_ccinv", 128'(log_q[i0+1].cci), 128'(4'b1101));
            check_eq("s4_c2_dwait", 128'(log_q[i0+1].dw), 128'(4'b1101));
            check_eq("s4_c2_ccwait", 128'(log_q[i0+1].ccw), 128'(0));
        end
        check_eq("s4_inv_cycles", 128'(n_inv), 128'd1);
        check_eq("s4_no_ram", 128'({any_ren, any_wen}), 128'(0));

        // 5: all four write back from reset; CPU0 re-requests at once and waits for CPU3.
        nRST = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            daddr[c*AW +: AW] = 32'h1000 * (c + 1);
            store_base[c] = 32'hC0000000 | (32'(c) << 20);
            cnt5[c] = 0;
        end
        dWEN = 4'hF;
        log_q.delete();
        @(negedge CLK);
        nRST = 1'b1;
        for (int t = 0; t < 400 && order.size() < 5; t++) begin
            sample();
            for (int c = 0; c < CPUS; c++) begin
                if (dwait[c] == 1'b0) begin
                    cnt5[c]++;
                    if (cnt5[c] == WORDS) begin
                        cnt5[c] = 0;
                        order.push_back(c);
                        $display("txn s5 wb cpu%0d", c);
                        if (!(c == 0 && order.size() == 1)) dWEN[c] = 1'b0;
                    end
                end
            end
        end
        dWEN = '0;
        check_eq("s5_count", 128'(order.size()), 128'd5);
        if (order.size() == 5) begin
            check_eq("s5_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]},
                     128'h01230);
        end
        collect(1'b1);
        check_eq("s5_first_beat", (comps.size() > 0) ? {comps[0].addr, comps[0].store, 28'h0, comps[0].ccw}
                                                      : 128'h0,
                 {32'h1000, 32'hC0000000, 28'h0, 4'h0});

        // 6: async reset in the middle of a C2C transfer; arbitration restarts at CPU0.
        idle(2);
        store_base[3] = 32'hAAAA0000;
        ccwrite[3] = 1'b1;
        daddr[0 +: AW] = 32'h200;
        dREN[0] = 1'b1;
        first = 0;
        for (int t = 0; t < 40 && first == 0; t++) begin
            sample();
            if (dwait[0] == 1'b0) first = 1;
        end
        sample();
        check_eq("s6_pre_beat1", 128'({ramWEN, ccbeat}), 128'(2'b11));
        #1 nRST = 1'b0;
        #1;
        check_eq("s6_rst_ramwen", 128'(ramWEN), 128'(0));
        check_eq("s6_rst_dwait", 128'(dwait), 128'(4'hF));
        check_eq("s6_rst_ccwait", 128'(ccwait), 128'(0));
        check_eq("s6_rst_beat", 128'(ccbeat), 128'(0));
        dREN = '0; ccwrite = '0;
        @(negedge CLK);
        nRST = 1'b1;
        daddr[0 +: AW] = 32'h500;
        daddr[1*AW +: AW] = 32'h600;
        dWEN[0] = 1'b1; dWEN[1] = 1'b1;
        first = -1;
        for (int t = 0; t < 40 && first < 0; t++) begin
            sample();
            if (dwait[0] == 1'b0)      first = 0;
            else if (dwait[1] == 1'b0) first = 1;
        end
        check_eq("s6_first_grant", 128'(first), 128'd0);
        check_eq("s6_first_addr", 128'(ramaddr), 128'h500);
        if (first == 0) wait_done("s6a", 0, 1, 40);
        dWEN[0] = 1'b0;
        wait_done("s6b", 1, 2, 60);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
